wb_scoreboard: RTL and testbench

Per-issue-slot register scoreboard placed between the instruction buffer and dispatch, consuming the writeback stream that the commit stage produces. It holds one decoded instruction in a stage register and tracks in-flight destination registers per warp. The instruction is released to dispatch only when none of its source or destination registers has a pending write. Pending bits clear on the final (eop) writeback packet of the producing instruction; writeback has no backpressure, so every packet is absorbed.

---
 rtl/wb_scoreboard_if.sv | 52 +++++
 rtl/wb_scoreboard.sv | 138 +++++++++++++
 tb/tb_wb_scoreboard.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_scoreboard_if.sv
// Bus bundle for the writeback scoreboard: writeback stream, ibuffer-side input,
// dispatch-side output and status. The master drives writeback/input, the slave is the scoreboard.
interface wb_scoreboard_if #(
    parameter int PER_ISSUE_WARPS = 4,
    parameter int NUM_REGS        = 64,
    parameter int DATAW           = 128,
    parameter int CTR_BITS        = 44
);
    localparam int WIS_W   = (PER_ISSUE_WARPS > 1) ? $clog2(PER_ISSUE_WARPS) : 1;
    localparam int NR_BITS = $clog2(NUM_REGS);

    logic                       wb_valid;
    logic [WIS_W-1:0]           wb_wis;
    logic [NR_BITS-1:0]         wb_rd;
    logic                       wb_eop;

    logic                       in_valid;
    logic                       in_ready;
    logic [WIS_W-1:0]           in_wis;
    logic                       in_wb;
    logic [NR_BITS-1:0]         in_rd;
    logic [NR_BITS-1:0]         in_rs1;
    logic [NR_BITS-1:0]         in_rs2;
    logic [NR_BITS-1:0]         in_rs3;
    logic [DATAW-1:0]           in_data;

    logic                       out_valid;
    logic                       out_ready;
    logic [WIS_W-1:0]           out_wis;
    logic [DATAW-1:0]           out_data;

    logic [PER_ISSUE_WARPS-1:0] warp_busy;
    logic [CTR_BITS-1:0]        stall_cycles;

    modport master (
        output wb_valid, wb_wis, wb_rd, wb_eop,
        output in_valid, in_wis, in_wb, in_rd, in_rs1, in_rs2, in_rs3, in_data,
        input  in_ready,
        input  out_valid, out_wis, out_data,
        output out_ready,
        input  warp_busy, stall_cycles
    );

    modport slave (
        input  wb_valid, wb_wis, wb_rd, wb_eop,
        input  in_valid, in_wis, in_wb, in_rd, in_rs1, in_rs2, in_rs3, in_data,
        output in_ready,
        output out_valid, out_wis, out_data,
        input  out_ready,
        output warp_busy, stall_cycles
    );
endinterface

// File: rtl/wb_scoreboard.sv
// Per-issue-slot register scoreboard: one-entry instruction stage released to dispatch only
// when none of its registers has a pending write; pending bits clear on eop writeback packets.
module wb_scoreboard #(
    parameter int PER_ISSUE_WARPS = 4,
    parameter int NUM_REGS        = 64,
    parameter int DATAW           = 128,
    parameter int CTR_BITS        = 44
) (
    input  logic             clk,
    input  logic             reset,
    wb_scoreboard_if.slave   sb
);
    localparam int WIS_W   = (PER_ISSUE_WARPS > 1) ? $clog2(PER_ISSUE_WARPS) : 1;
    localparam int NR_BITS = $clog2(NUM_REGS);

    logic [PER_ISSUE_WARPS-1:0][NUM_REGS-1:0] inuse_q, inuse_d;

    logic                 stage_valid_q, stage_valid_d;
    logic [WIS_W-1:0]     stage_wis_q,   stage_wis_d;
    logic                 stage_wb_q,    stage_wb_d;
    logic [NR_BITS-1:0]   stage_rd_q,    stage_rd_d;
    logic [NR_BITS-1:0]   stage_rs1_q,   stage_rs1_d;
    logic [NR_BITS-1:0]   stage_rs2_q,   stage_rs2_d;
    logic [NR_BITS-1:0]   stage_rs3_q,   stage_rs3_d;
    logic [DATAW-1:0]     stage_data_q,  stage_data_d;
    logic [CTR_BITS-1:0]  stall_q,       stall_d;

    logic hazard;
    logic out_valid;
    logic out_fire;
    logic in_ready;
    logic in_fire;
    logic set_en;
    logic clr_en;

    // Hazard looks only at registered pending bits; a same-cycle eop does not bypass.
    always_comb begin
        hazard = inuse_q[stage_wis_q][stage_rs1_q]
               | inuse_q[stage_wis_q][stage_rs2_q]
               | inuse_q[stage_wis_q][stage_rs3_q]
               | (stage_wb_q & inuse_q[stage_wis_q][stage_rd_q]);
        out_valid = stage_valid_q && !hazard;
        out_fire  = out_valid && sb.out_ready;
        in_ready  = !stage_valid_q || out_fire;
        in_fire   = sb.in_valid && in_ready;
        set_en    = out_fire && stage_wb_q && (stage_rd_q != '0);
        clr_en    = sb.wb_valid && sb.wb_eop;
    end

    // Clear first so that a colliding set on the same bit wins.
    always_comb begin
        inuse_d = inuse_q;
        if (clr_en) begin
            inuse_d[sb.wb_wis][sb.wb_rd] = 1'b0;
        end
        if (set_en) begin
            inuse_d[stage_wis_q][stage_rd_q] = 1'b1;
        end
    end

    always_comb begin
        stage_valid_d = stage_valid_q;
        stage_wis_d   = stage_wis_q;
        stage_wb_d    = stage_wb_q;
        stage_rd_d    = stage_rd_q;
        stage_rs1_d   = stage_rs1_q;
        stage_rs2_d   = stage_rs2_q;
        stage_rs3_d   = stage_rs3_q;
        stage_data_d  = stage_data_q;
        if (in_fire) begin
            stage_valid_d = 1'b1;
            stage_wis_d   = sb.in_wis;
            stage_wb_d    = sb.in_wb;
            stage_rd_d    = sb.in_rd;
            stage_rs1_d   = sb.in_rs1;
            stage_rs2_d   = sb.in_rs2;
            stage_rs3_d   = sb.in_rs3;
            stage_data_d  = sb.in_data;
        end else if (out_fire) begin
            stage_valid_d = 1'b0;
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (stage_valid_q && hazard) begin
            stall_d = stall_q + CTR_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inuse_q       <= '0;
            stage_valid_q <= 1'b0;
            stage_wis_q   <= '0;
            stage_wb_q    <= 1'b0;
            stage_rd_q    <= '0;
            stage_rs1_q   <= '0;
            stage_rs2_q   <= '0;
            stage_rs3_q   <= '0;
            stage_data_q  <= '0;
            stall_q       <= '0;
        end else begin
            inuse_q       <= inuse_d;
            stage_valid_q <= stage_valid_d;
            stage_wis_q   <= stage_wis_d;
            stage_wb_q    <= stage_wb_d;
            stage_rd_q    <= stage_rd_d;
            stage_rs1_q   <= stage_rs1_d;
            stage_rs2_q   <= stage_rs2_d;
            stage_rs3_q   <= stage_rs3_d;
            stage_data_q  <= stage_data_d;
            stall_q       <= stall_d;
        end
    end

    // Both conditions mean the commit stage and the scoreboard disagree about what is in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(set_en && clr_en && (sb.wb_wis == stage_wis_q) && (sb.wb_rd == stage_rd_q)))
                else $error("wb_scoreboard: set and clear collide on warp %0d reg %0d", sb.wb_wis, sb.wb_rd);
            assert (!(clr_en && !inuse_q[sb.wb_wis][sb.wb_rd]))
                else $error("wb_scoreboard: clear of idle reg, warp %0d reg %0d", sb.wb_wis, sb.wb_rd);
        end
    end

    always_comb begin
        for (int w = 0; w < PER_ISSUE_WARPS; w++) begin
            sb.warp_busy[w] = |inuse_q[w];
        end
    end

    assign sb.in_ready     = in_ready;
    assign sb.out_valid    = out_valid;
    assign sb.out_wis      = stage_wis_q;
    assign sb.out_data     = stage_data_q;
    assign sb.stall_cycles = stall_q;
endmodule

// File: tb/tb_wb_scoreboard.sv
// Self-checking bench for wb_scoreboard: directed vector table, backpressure and reset
// sequences, then randomized traffic against a pending-register reference model.
module tb_wb_scoreboard;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wb_scoreboard_if #(.PER_ISSUE_WARPS(4), .NUM_REGS(64), .DATAW(128), .CTR_BITS(44)) sb ();

    wb_scoreboard #(.PER_ISSUE_WARPS(4), .NUM_REGS(64), .DATAW(128), .CTR_BITS(44)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sb)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit [1:0]   wis;
        bit         wb;
        bit [5:0]   rd, rs1, rs2, rs3;
        bit [127:0] data;
    } ins_t;

    typedef struct {
        bit       iv;
        bit [1:0] wis;
        bit       wb;
        bit [5:0] rd, rs1;
        bit       wv;
        bit [1:0] wwis;
        bit [5:0] wrd;
        bit       weop;
        bit       eov, eir;
        bit [3:0] ebusy;
        int       estall;
    } vec_t;

    vec_t tbl[18];
    ins_t dq[5];

    bit          pend[4][64];
    bit          m_held;
    ins_t        m_ins;
    logic [43:0] m_stall;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(bit iv, bit [1:0] wis, bit wb, bit [5:0] rd, bit [5:0] rs1,
                                bit wv, bit [1:0] wwis, bit [5:0] wrd, bit weop,
                                bit eov, bit eir, bit [3:0] ebusy, int estall);
        vec_t v;
        v.iv = iv; v.wis = wis; v.wb = wb; v.rd = rd; v.rs1 = rs1;
        v.wv = wv; v.wwis = wwis; v.wrd = wrd; v.weop = weop;
        v.eov = eov; v.eir = eir; v.ebusy = ebusy; v.estall = estall;
        return v;
    endfunction

    function automatic ins_t rand_ins();
        ins_t i;
        i.wis  = 2'($urandom_range(0, 3));
        i.wb   = 1'($urandom_range(0, 1));
        i.rd   = 6'($urandom_range(0, 7));
        i.rs1  = 6'($urandom_range(0, 7));
        i.rs2  = ($urandom_range(0, 9) < 3) ? 6'($urandom_range(1, 7)) : 6'd0;
        i.rs3  = ($urandom_range(0, 9) < 2) ? 6'($urandom_range(1, 7)) : 6'd0;
        i.data = {$urandom, $urandom, $urandom, $urandom};
        return i;
    endfunction

    task automatic drive_ins(input bit v, input ins_t i);
        sb.in_valid = v;
        sb.in_wis   = i.wis;
        sb.in_wb    = i.wb;
        sb.in_rd    = i.rd;
        sb.in_rs1   = i.rs1;
        sb.in_rs2   = i.rs2;
        sb.in_rs3   = i.rs3;
        sb.in_data  = i.data;
    endtask

    task automatic drive_wb(input bit v, input bit [1:0] w, input bit [5:0] r, input bit eop);
        sb.wb_valid = v;
        sb.wb_wis   = w;
        sb.wb_rd    = r;
        sb.wb_eop   = eop;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference model: check this cycle's outputs, then advance to the next edge.
    task automatic model_cycle();
        bit       haz, ev, er, fire;
        bit [3:0] busy;
        ins_t     cur;
        @(negedge clk);
        haz = m_held && (pend[m_ins.wis][m_ins.rs1] || pend[m_ins.wis][m_ins.rs2] ||
                         pend[m_ins.wis][m_ins.rs3] || (m_ins.wb && pend[m_ins.wis][m_ins.rd]));
        ev   = m_held && !haz;
        er   = !m_held || (ev && sb.out_ready);
        fire = ev && sb.out_ready;
        busy = '0;
        for (int w = 0; w < 4; w++)
            for (int r = 0; r < 64; r++)
                if (pend[w][r]) busy[w] = 1'b1;
        chk("rnd_out_valid", sb.out_valid, ev);
        chk("rnd_in_ready", sb.in_ready, er);
        chk("rnd_warp_busy", sb.warp_busy, busy);
        chk("rnd_stall", sb.stall_cycles, m_stall);
        if (m_held) begin
            chk("rnd_out_data", sb.out_data, m_ins.data);
            chk("rnd_out_wis", sb.out_wis, m_ins.wis);
        end
        if (sb.wb_valid && sb.wb_eop) pend[sb.wb_wis][sb.wb_rd] = 1'b0;
        if (fire && m_ins.wb && m_ins.rd != 0) pend[m_ins.wis][m_ins.rd] = 1'b1;
        if (haz) m_stall = m_stall + 44'd1;
        cur.wis = sb.in_wis; cur.wb = sb.in_wb; cur.rd = sb.in_rd;
        cur.rs1 = sb.in_rs1; cur.rs2 = sb.in_rs2; cur.rs3 = sb.in_rs3; cur.data = sb.in_data;
        if (sb.in_valid && er) begin
            m_held = 1'b1;
            m_ins  = cur;
        end else if (fire) begin
            m_held = 1'b0;
        end
        next_cycle();
    endtask

    // Writeback for a random pending register (eop or not), else a harmless non-eop packet.
    task automatic rand_wb(input int pct);
        bit [1:0] pw[$];
        bit [5:0] pr[$];
        int       k;
        for (int w = 0; w < 4; w++)
            for (int r = 0; r < 64; r++)
                if (pend[w][r]) begin
                    pw.push_back(2'(w));
                    pr.push_back(6'(r));
                end
        if ($urandom_range(0, 99) >= pct) begin
            drive_wb(0, 0, 0, 0);
        end else if (pw.size() > 0 && $urandom_range(0, 3) != 0) begin
            k = $urandom_range(0, pw.size() - 1);
            drive_wb(1, pw[k], pr[k], 1'($urandom_range(0, 1)));
        end else begin
            drive_wb(1, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)), 0);
        end
    endtask

    initial begin
        ins_t z;
        ins_t ti;
        z = '{default: '0};

        tbl[0]  = mk(1, 0, 1, 5, 0,  0, 0, 0, 0,  0, 1, 4'b0000, 0);
        tbl[1]  = mk(1, 0, 0, 0, 5,  0, 0, 0, 0,  1, 1, 4'b0000, 0);
        tbl[2]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 4'b0001, 0);
        tbl[3]  = mk(0, 0, 0, 0, 0,  1, 0, 5, 0,  0, 0, 4'b0001, 1);
        tbl[4]  = mk(0, 0, 0, 0, 0,  1, 0, 5, 1,  0, 0, 4'b0001, 2);
        tbl[5]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 1, 4'b0000, 3);
        tbl[6]  = mk(1, 0, 1, 5, 0,  0, 0, 0, 0,  0, 1, 4'b0000, 3);
        tbl[7]  = mk(1, 1, 0, 0, 5,  0, 0, 0, 0,  1, 1, 4'b0000, 3);
        tbl[8]  = mk(1, 0, 1, 0, 0,  0, 0, 0, 0,  1, 1, 4'b0001, 3);
        tbl[9]  = mk(1, 0, 0, 0, 0,  0, 0, 0, 0,  1, 1, 4'b0001, 3);
        tbl[10] = mk(0, 0, 0, 0, 0,  1, 0, 5, 1,  1, 1, 4'b0001, 3);
        tbl[11] = mk(1, 3, 1, 9, 0,  0, 0, 0, 0,  0, 1, 4'b0000, 3);
        tbl[12] = mk(1, 3, 1, 9, 0,  0, 0, 0, 0,  1, 1, 4'b0000, 3);
        tbl[13] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 4'b1000, 3);
        tbl[14] = mk(0, 0, 0, 0, 0,  1, 3, 9, 1,  0, 0, 4'b1000, 4);
        tbl[15] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 1, 4'b0000, 5);
        tbl[16] = mk(0, 0, 0, 0, 0,  1, 3, 9, 1,  0, 1, 4'b1000, 5);
        tbl[17] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 1, 4'b0000, 5);

        reset = 1'b1;
        drive_ins(0, z);
        drive_wb(0, 0, 0, 0);
        sb.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Directed table: one record per cycle.
        for (int i = 0; i < 18; i++) begin
            ti = z;
            ti.wis = tbl[i].wis; ti.wb = tbl[i].wb; ti.rd = tbl[i].rd; ti.rs1 = tbl[i].rs1;
            ti.data = {32'hc0de_0000 + 32'(i), 96'h0};
            drive_ins(tbl[i].iv, ti);
            drive_wb(tbl[i].wv, tbl[i].wwis, tbl[i].wrd, tbl[i].weop);
            sb.out_ready = 1'b1;
            @(negedge clk);
            chk($sformatf("tbl%0d_out_valid", i), sb.out_valid, tbl[i].eov);
            chk($sformatf("tbl%0d_in_ready", i), sb.in_ready, tbl[i].eir);
            chk($sformatf("tbl%0d_warp_busy", i), sb.warp_busy, tbl[i].ebusy);
            chk($sformatf("tbl%0d_stall", i), sb.stall_cycles, 128'(tbl[i].estall));
            next_cycle();
        end
        drive_wb(0, 0, 0, 0);

        // Backpressure: stage holds D0 while dispatch is stalled, then streams 1/cycle.
        for (int k = 0; k < 5; k++) begin
            dq[k] = z;
            dq[k].wis = 2;
            dq[k].data = {$urandom, $urandom, $urandom, $urandom};
        end
        sb.out_ready = 1'b0;
        drive_ins(1, dq[0]);
        @(negedge clk);
        chk("bp_load_in_ready", sb.in_ready, 1);
        next_cycle();
        drive_ins(1, dq[1]);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_hold_out_valid", sb.out_valid, 1);
            chk("bp_hold_in_ready", sb.in_ready, 0);
            chk("bp_hold_out_data", sb.out_data, dq[0].data);
            chk("bp_hold_out_wis", sb.out_wis, 2);
            chk("bp_hold_stall", sb.stall_cycles, 5);
            next_cycle();
        end
        sb.out_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            drive_ins(1, dq[k]);
            @(negedge clk);
            chk("bp_stream_out_valid", sb.out_valid, 1);
            chk("bp_stream_in_ready", sb.in_ready, 1);
            chk("bp_stream_out_data", sb.out_data, dq[k-1].data);
            next_cycle();
        end
        drive_ins(0, z);
        @(negedge clk);
        chk("bp_last_out_data", sb.out_data, dq[4].data);
        chk("bp_last_out_valid", sb.out_valid, 1);
        next_cycle();
        @(negedge clk);
        chk("bp_empty_out_valid", sb.out_valid, 0);
        next_cycle();

        // Reset while warp 2 reg 7 is pending and a dependent instruction stalls.
        ti = z; ti.wis = 2; ti.wb = 1; ti.rd = 7;
        drive_ins(1, ti);
        next_cycle();
        ti = z; ti.wis = 2; ti.rs1 = 7;
        drive_ins(1, ti);
        @(negedge clk);
        chk("rst_pre_fire", sb.out_valid, 1);
        next_cycle();
        drive_ins(0, z);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_stall_out_valid", sb.out_valid, 0);
            chk("rst_stall_busy", sb.warp_busy, 4'b0100);
            chk("rst_stall_count", sb.stall_cycles, 128'(5 + c));
            next_cycle();
        end
        reset = 1'b1;
        drive_wb(1, 2, 7, 1);
        next_cycle();
        reset = 1'b0;
        drive_wb(0, 0, 0, 0);
        @(negedge clk);
        chk("rst_out_valid", sb.out_valid, 0);
        chk("rst_in_ready", sb.in_ready, 1);
        chk("rst_warp_busy", sb.warp_busy, 0);
        chk("rst_stall", sb.stall_cycles, 0);
        next_cycle();
        ti = z; ti.wis = 2; ti.rs1 = 7;
        drive_ins(1, ti);
        next_cycle();
        drive_ins(0, z);
        @(negedge clk);
        chk("rst_pending_dropped", sb.out_valid, 1);
        next_cycle();
        @(negedge clk);
        chk("rst_after_out_valid", sb.out_valid, 0);
        chk("rst_after_stall", sb.stall_cycles, 0);
        next_cycle();

        // Randomized traffic against the model, starting from the clean post-reset state.
        for (int w = 0; w < 4; w++)
            for (int r = 0; r < 64; r++)
                pend[w][r] = 1'b0;
        m_held  = 1'b0;
        m_ins   = z;
        m_stall = '0;
        for (int c = 0; c < 3000; c++) begin
            drive_ins(1'($urandom_range(0, 9) < 7), rand_ins());
            sb.out_ready = ($urandom_range(0, 9) < 8);
            rand_wb(40);
            model_cycle();
        end
        drive_ins(0, z);
        sb.out_ready = 1'b1;
        for (int c = 0; c < 300; c++) begin
            rand_wb(100);
            if (sb.wb_valid) sb.wb_eop = sb.wb_eop | pend[sb.wb_wis][sb.wb_rd];
            model_cycle();
        end
        drive_wb(0, 0, 0, 0);
        @(negedge clk);
        chk("drain_warp_busy", sb.warp_busy, 0);
        chk("drain_in_ready", sb.in_ready, 1);
        chk("drain_out_valid", sb.out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
